// File: rtl/bin_to_gray_gen.sv
// Binary-to-Gray encoder and autonomous Gray-sequence generator
// with valid/ready handshakes on both sides.
module bin_to_gray_gen #(
  parameter int WIDTH = 4,
  parameter int DWELL = 5
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic             modo,
  input  logic [WIDTH-1:0] bin_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_mirror,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wrap
);

  localparam int DW =
    (DWELL > 2) ? $clog2(DWELL - 1) : 1;
  localparam logic [DW-1:0] DLOAD =
    DW'((DWELL > 1) ? DWELL - 2 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    SW_PRES,
    SW_DWELL
  } state_t;

  function automatic logic [WIDTH-1:0] to_gray(
    input logic [WIDTH-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [WIDTH-1:0] nxt_bin;
  logic             enc_side;

  assign nxt_bin  = bin_q + WIDTH'(1);
  assign enc_side = (state_q == IDLE) ||
                    (state_q == ENC);

  assign in_ready = !reset && !modo &&
                    enc_side &&
                    (!valid_q || out_ready);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    gray_d  = gray_q;
    valid_d = valid_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (modo) begin
          state_d = SW_PRES;
          bin_d   = '0;
          gray_d  = '0;
          valid_d = 1'b1;
        end else if (in_valid) begin
          state_d = ENC;
          bin_d   = bin_in;
          gray_d  = to_gray(bin_in);
          valid_d = 1'b1;
        end
      end
      ENC: begin
        if (in_valid && in_ready) begin
          bin_d   = bin_in;
          gray_d  = to_gray(bin_in);
          valid_d = 1'b1;
        end else if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      SW_PRES: begin
        if (out_ready) begin
          if (!modo) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else if (DWELL == 1) begin
            bin_d   = nxt_bin;
            gray_d  = to_gray(nxt_bin);
            valid_d = 1'b1;
            wrap_d  = &bin_q;
          end else begin
            state_d = SW_DWELL;
            valid_d = 1'b0;
            dwell_d = DLOAD;
          end
        end
      end
      SW_DWELL: begin
        // Outputs keep the last code while invisible
        if (dwell_q == '0) begin
          state_d = SW_PRES;
          bin_d   = nxt_bin;
          gray_d  = to_gray(nxt_bin);
          valid_d = 1'b1;
          wrap_d  = &bin_q;
        end else begin
          dwell_d = dwell_q - DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      dwell_q <= dwell_d;
    end
  end

  assign gray_out   = gray_q;
  assign bin_mirror = bin_q;
  assign out_valid  = valid_q;
  assign wrap       = wrap_q;

endmodule

// File: doc/bin_to_gray_gen.md
# bin_to_gray_gen

Binary-to-Gray encoder and Gray-sequence generator with valid/ready handshakes. It is the transmit-side counterpart of the Gray-to-binary decoder: it produces the Gray words that the decoder consumes. In encode mode it converts binary samples one-for-one. In sweep mode it autonomously emits the full Gray count sequence with a programmable dwell between codes, which lets it drive decoder benches and board bring-up.

## Interface
- WIDTH, 4, code width in bits (≥2)
- DWELL, 5, cycles from one accepted sweep code to the next presented code (≥1)

- reloj  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- modo  in  1  0 = encode, 1 = sweep; sampled only in IDLE
- bin_in  in  WIDTH  binary sample (encode mode)
- in_valid  in  1  bin_in valid
- in_ready  out  1  block accepts bin_in this cycle
- gray_out  out  WIDTH  registered Gray word
- bin_mirror  out  WIDTH  registered binary value that gray_out encodes
- out_valid  out  1  gray_out valid
- out_ready  in  1  sink accepts gray_out this cycle
- wrap  out  1  one-cycle pulse when a sweep presents code 0 after the all-ones code

## Operation
- Encoding rule: gray = b ^ (b >> 1), with a logical shift at WIDTH bits. bin_mirror always holds b.
- States: IDLE, ENC, SW_PRES, SW_DWELL.
- IDLE:
  - out_valid = 0.
  - modo=1 → SW_PRES, with counter = 0, gray_out = 0, bin_mirror = 0.
  - modo=0 and in_valid → ENC, with the word loaded.
- ENC:
  - out_valid = 1.
  - in_ready = (modo==0) && (!out_valid || out_ready) in IDLE and ENC; otherwise in_ready = 0.
  - Input accepted while out_ready=1: the new word replaces the old one and the state stays ENC (full throughput).
  - out_ready=1 with no new input → IDLE.
  - out_ready=0: gray_out, bin_mirror and out_valid hold. No loss, no overwrite.
- SW_PRES:
  - out_valid = 1, holding the current code until out_ready.
  - Handshake with modo=0 → IDLE (sweep abort at a code boundary only).
  - Handshake with DWELL=1 → next code presented the following cycle; the state stays SW_PRES.
  - Handshake with DWELL>1 → SW_DWELL with the dwell counter = DWELL-2.
- SW_DWELL:
  - out_valid = 0; outputs hold their last value.
  - Counter reaches 0 → increment the binary counter mod 2^WIDTH, load gray_out and bin_mirror, → SW_PRES.
  - modo is ignored here.
- Wrap-around: the increment from all-ones to 0 asserts wrap for the first cycle that code 0 is valid. The initial code 0 at sweep entry does not assert wrap.
- Every consecutive sweep code pair differs in exactly one bit.
- Reset mid-operation: the state returns to IDLE on the next edge. Any pending word is discarded.

## Timing
- Reset values: gray_out = 0, bin_mirror = 0, out_valid = 0, wrap = 0. in_ready = 0 while reset is high.
- Encode latency: bin_in accepted at edge N → out_valid/gray_out valid after edge N (registered, 1 cycle).
- Sweep entry: modo=1 sampled in IDLE at edge N → code 0 valid after edge N.
- Sweep spacing:
  - With out_ready tied high, out_valid is high for 1 cycle per code.
  - Consecutive codes start DWELL cycles apart.
  - A full period is 2^WIDTH × DWELL cycles.
- Outputs are registered. in_ready is combinational from state, modo, out_valid and out_ready only; it never depends on in_valid.

## Test plan
- Reset:
  - Hold reset for 3 cycles with in_valid=1, bin_in=4'b1111 and modo=1.
  - Required: gray_out=0, out_valid=0, in_ready=0, wrap=0 throughout.
- Encode all values:
  - Stream bin 0..15 with out_ready=1.
  - Required: gray 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, one per cycle after 1-cycle latency.
  - Required: bin_mirror equals the input.
- Backpressure:
  - Send bin 4'b1011 with out_ready=0 for 4 cycles.
  - Required: gray_out=4'b1110 stable, in_ready=0, and a second input is not taken until out_ready=1.
- Sweep with DWELL=5:
  - out_ready=1, modo=1.
  - Required: codes follow the sequence above with out_valid pulsing every 5 cycles.
  - Required: single-bit change between codes.
  - Required: wrap high only with the code 0000 that follows 1000, 80 cycles after entry.
- Sweep abort and stall:
  - Drop modo at code 0110 while out_ready=0.
  - Required: 0110 held until out_ready=1; then IDLE, out_valid=0, in_ready=1.
- Reset mid-sweep:
  - Assert reset at code 1101.
  - Required: next cycle out_valid=0 and gray_out=0.
  - Required: restarting the sweep begins at 0000 with no wrap pulse.
